dm_copy_engine: RTL and testbench

//  Bus master for the data memory (DM) word port: drives we/addr/in_d and consumes out_d.
//  On a start pulse it either copies a block of words (COPY) or writes a constant pattern (FILL).

---
 rtl/dm_copy_engine_if.sv | 32 +++
 rtl/dm_copy_engine.sv | 142 ++++++++++++++
 tb/tb_dm_copy_engine.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_copy_engine_if.sv
// Command/status and data-memory word-port bundle for the DM copy engine.
// The engine holds the master modport (it masters the DM port and answers
// commands); the slave modport is the command issuer / memory side.
interface dm_copy_engine_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  // command side
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] pattern;
  logic          busy;
  logic          done;
  // data-memory word port
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_in_d;
  logic [DW-1:0] dm_out_d;

  modport master (
    input  start, mode, src, dst, len, pattern, dm_out_d,
    output busy, done, dm_we, dm_addr, dm_in_d
  );

  modport slave (
    output start, mode, src, dst, len, pattern, dm_out_d,
    input  busy, done, dm_we, dm_addr, dm_in_d
  );
endinterface

// File: rtl/dm_copy_engine.sv
// DM copy/fill engine: on a start strobe either copies len words src->dst
// (one read cycle and one write cycle per word) or writes a constant pattern
// to len words at dst (one cycle per word). Pointers wrap modulo 2^AW.
// All bus outputs are registers loaded with the value the next state needs,
// so nothing combinational leads from start to dm_we.
module dm_copy_engine #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  dm_copy_engine_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   REM_ONE = (AW+1)'(1);

  state_t        state_r;
  logic [AW-1:0] src_ptr_r;
  logic [AW-1:0] dst_ptr_r;
  logic [AW:0]   remaining_r;
  logic [DW-1:0] pattern_r;
  logic          busy_r;
  logic          done_r;
  logic          dm_we_r;
  logic [AW-1:0] dm_addr_r;
  logic [DW-1:0] dm_in_d_r;   // doubles as the copy read buffer

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.dm_we   = dm_we_r;
  assign bus.dm_addr = dm_addr_r;
  assign bus.dm_in_d = dm_in_d_r;

  // Sequencer: state, pointers and the registered bus outputs for the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      src_ptr_r   <= '0;
      dst_ptr_r   <= '0;
      remaining_r <= '0;
      pattern_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dm_we_r     <= 1'b0;
      dm_addr_r   <= '0;
      dm_in_d_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            src_ptr_r   <= bus.src;
            dst_ptr_r   <= bus.dst;
            remaining_r <= bus.len;
            pattern_r   <= bus.pattern;
            if (bus.len == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else if (bus.mode == 1'b0) begin
              state_r   <= ST_RD;
              busy_r    <= 1'b1;
              dm_addr_r <= bus.src;
            end else begin
              state_r   <= ST_FILL;
              busy_r    <= 1'b1;
              dm_we_r   <= 1'b1;
              dm_addr_r <= bus.dst;
              dm_in_d_r <= bus.pattern;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD: begin
          // capture the word read this cycle and present it for writing
          dm_in_d_r <= bus.dm_out_d;
          src_ptr_r <= src_ptr_r + PTR_ONE;
          dm_we_r   <= 1'b1;
          dm_addr_r <= dst_ptr_r;
          state_r   <= ST_WR;
        end
        ST_WR: begin
          dst_ptr_r   <= dst_ptr_r + PTR_ONE;
          remaining_r <= remaining_r - REM_ONE;
          if (remaining_r == REM_ONE) begin
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            dm_we_r   <= 1'b0;
            dm_addr_r <= '0;
            dm_in_d_r <= '0;
          end else begin
            state_r   <= ST_RD;
            dm_we_r   <= 1'b0;
            dm_addr_r <= src_ptr_r;
          end
        end
        ST_FILL: begin
          dst_ptr_r   <= dst_ptr_r + PTR_ONE;
          remaining_r <= remaining_r - REM_ONE;
          if (remaining_r == REM_ONE) begin
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            dm_we_r   <= 1'b0;
            dm_addr_r <= '0;
            dm_in_d_r <= '0;
          end else begin
            state_r   <= ST_FILL;
            dm_addr_r <= dst_ptr_r + PTR_ONE;
            dm_in_d_r <= pattern_r;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          dm_we_r   <= 1'b0;
          dm_addr_r <= '0;
          dm_in_d_r <= '0;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          dm_we_r   <= 1'b0;
          dm_addr_r <= '0;
          dm_in_d_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Self-checking bench for dm_copy_engine: a behavioural DM model plus a
// word-array reference that applies each command as a simple forward loop.
module tb_dm_copy_engine;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_copy_engine_if #(.AW(AW), .DW(DW)) bus ();
  dm_copy_engine #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] mem     [N];
  logic [DW-1:0] ref_mem [N];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  int wr_count   = 0;
  int done_count = 0;
  int vectors    = 0;
  int miscompares = 0;

  // DM: asynchronous read, write on clock edge; bench preload port has priority
  assign bus.dm_out_d = mem[bus.dm_addr];
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.dm_we === 1'b1) mem[bus.dm_addr] <= bus.dm_in_d;
    if (bus.dm_we === 1'b1) wr_count <= wr_count + 1;
    if (bus.done === 1'b1) done_count <= done_count + 1;
  end

  task automatic preload(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = AW'(a); pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
    ref_mem[a % N] = d;
  endtask

  // Reference: forward word-by-word, modulo-N addressing
  task automatic model_cmd(input logic m, input int s, input int d, input int l,
                           input logic [DW-1:0] p);
    for (int i = 0; i < l; i++)
      ref_mem[(d + i) % N] = m ? p : ref_mem[(s + i) % N];
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < N; i++)
      if (mem[i] !== ref_mem[i]) begin bad++; if (first < 0) first = i; end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s: %0d words differ, first at %0d got %h required %h",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  // Issue one command; optional second start strobe at cycle 'inject' while busy
  task automatic run_cmd(input logic m, input int s, input int d, input int l,
                         input logic [DW-1:0] p, input int inject,
                         output int lat, output int busy_bad,
                         output int writes, output int dones);
    int w0, d0;
    w0 = wr_count; d0 = done_count;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.src = AW'(s); bus.dst = AW'(d);
    bus.len = (AW+1)'(l); bus.pattern = p;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_bad = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (inject > 0 && lat == inject) begin
        bus.start = 1'b1; bus.mode = 1'b1; bus.dst = AW'(200);
        bus.len = (AW+1)'(3); bus.pattern = 32'hBAD0_BAD0;
      end
      if (inject > 0 && lat == inject + 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        if (bus.busy !== 1'b0) busy_bad++;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      if (lat > 5000) break;
    end
    @(posedge clk); #1;
    writes = wr_count - w0;
    dones  = done_count - d0;
    model_cmd(m, s, d, l, p);
  endtask

  task automatic check_cmd(input string name, input logic m, input int l,
                           input int lat, input int busy_bad, input int writes,
                           input int dones);
    int exp_lat;
    exp_lat = (l == 0) ? 1 : (m ? l + 1 : 2 * l + 1);
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    vectors++;
    if (writes !== l) begin
      miscompares++;
      $display("FAIL %s writes: got %0d required %0d", name, writes, l);
    end
    vectors++;
    if (busy_bad !== 0) begin
      miscompares++;
      $display("FAIL %s busy: %0d bad cycles required 0", name, busy_bad);
    end
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("FAIL %s done pulses: got %0d required 1", name, dones);
    end
  endtask

  task automatic test_reset();
    int w0, d0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.dm_we} !== 3'b000 || bus.dm_addr !== 10'd0 ||
        bus.dm_in_d !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b we=%b addr=%0d din=%h required all 0",
               bus.busy, bus.done, bus.dm_we, bus.dm_addr, bus.dm_in_d);
    end
    rst = 1'b0;
    // abort a COPY after five cycles: two words written by then
    w0 = wr_count;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.src = 10'd500; bus.dst = 10'd600;
    bus.len = 11'd8; bus.pattern = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_cmd(1'b0, 500, 600, 2, 32'd0);
    vectors++;
    if ({bus.busy, bus.done, bus.dm_we} !== 3'b000 || bus.dm_addr !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_abort: busy=%b done=%b we=%b addr=%0d required 0",
               bus.busy, bus.done, bus.dm_we, bus.dm_addr);
    end
    d0 = done_count;
    repeat (20) @(negedge clk);
    vectors++;
    if (wr_count - w0 !== 2) begin
      miscompares++;
      $display("FAIL reset_writes: got %0d required 2", wr_count - w0);
    end
    vectors++;
    if (done_count !== d0) begin
      miscompares++;
      $display("FAIL reset_done: got %0d pulses required 0", done_count - d0);
    end
    check_mem("reset_mem");
  endtask

  task automatic test_copy();
    int lat, bb, wr, dn;
    for (int i = 0; i < 4; i++) preload(4 + i, DW'(8 * (i + 1)));
    run_cmd(1'b0, 4, 100, 4, 32'd0, 0, lat, bb, wr, dn);
    check_cmd("copy", 1'b0, 4, lat, bb, wr, dn);
    vectors++;
    if (mem[100] !== 32'd8 || mem[101] !== 32'd16 || mem[102] !== 32'd24 ||
        mem[103] !== 32'd32) begin
      miscompares++;
      $display("FAIL copy_data: got %0d %0d %0d %0d required 8 16 24 32",
               mem[100], mem[101], mem[102], mem[103]);
    end
    check_mem("copy_mem");
  endtask

  task automatic test_fill_wrap();
    int lat, bb, wr, dn;
    run_cmd(1'b1, 0, 1022, 4, 32'hDEADBEEF, 0, lat, bb, wr, dn);
    check_cmd("fill_wrap", 1'b1, 4, lat, bb, wr, dn);
    vectors++;
    if (mem[1022] !== 32'hDEADBEEF || mem[1023] !== 32'hDEADBEEF ||
        mem[0] !== 32'hDEADBEEF || mem[1] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL fill_wrap_data: got %h %h %h %h required DEADBEEF x4",
               mem[1022], mem[1023], mem[0], mem[1]);
    end
    check_mem("fill_wrap_mem");
  endtask

  task automatic test_len0();
    int lat, bb, wr, dn;
    run_cmd(1'b0, 7, 9, 0, 32'd0, 0, lat, bb, wr, dn);
    check_cmd("len0", 1'b0, 0, lat, bb, wr, dn);
    check_mem("len0_mem");
  endtask

  task automatic test_start_busy();
    int lat, bb, wr, dn;
    run_cmd(1'b0, 300, 50, 4, 32'd0, 3, lat, bb, wr, dn);
    check_cmd("start_busy", 1'b0, 4, lat, bb, wr, dn);
    check_mem("start_busy_mem");
  endtask

  task automatic test_overlap();
    int lat, bb, wr, dn;
    preload(10, 32'd7);
    preload(11, 32'd9);
    run_cmd(1'b0, 10, 11, 2, 32'd0, 0, lat, bb, wr, dn);
    check_cmd("overlap", 1'b0, 2, lat, bb, wr, dn);
    vectors++;
    if (mem[11] !== 32'd7 || mem[12] !== 32'd7) begin
      miscompares++;
      $display("FAIL overlap_data: got %0d %0d required 7 7", mem[11], mem[12]);
    end
    check_mem("overlap_mem");
  endtask

  task automatic test_full_len();
    int lat, bb, wr, dn;
    run_cmd(1'b1, 0, 333, N, 32'h5A5A_1234, 0, lat, bb, wr, dn);
    check_cmd("full_fill", 1'b1, N, lat, bb, wr, dn);
    check_mem("full_fill_mem");
    for (int i = 0; i < 8; i++) preload(i * 97, $urandom);
    run_cmd(1'b0, 900, 5, N, 32'd0, 0, lat, bb, wr, dn);
    check_cmd("full_copy", 1'b0, N, lat, bb, wr, dn);
    check_mem("full_copy_mem");
  endtask

  task automatic test_random();
    int lat, bb, wr, dn, s, d, l;
    logic m;
    for (int k = 0; k < 24; k++) begin
      m = 1'($urandom_range(0, 1));
      s = $urandom_range(0, N - 1);
      d = (k % 3 == 0) ? (s + $urandom_range(1, 6)) % N : $urandom_range(0, N - 1);
      l = (k % 5 == 4) ? 0 : $urandom_range(1, 40);
      run_cmd(m, s, d, l, $urandom, 0, lat, bb, wr, dn);
      check_cmd("random", m, l, lat, bb, wr, dn);
      check_mem("random_mem");
    end
  endtask

  initial begin
    rst = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
    bus.len = '0; bus.pattern = '0;
    for (int i = 0; i < N; i++) preload(i, $urandom);
    test_reset();
    test_copy();
    test_fill_wrap();
    test_len0();
    test_start_busy();
    test_overlap();
    test_full_len();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
